complex_logic_sweeper: RTL
==========================

// Module: complex_logic_sweeper
// PURPOSE
//  Exhaustive stimulus/response engine for the 4-input, 6-output complex_logic gate network.
//  Drives all 16 input vectors a,b,c,d into the network and samples y1..y6 after a settle window.
//  Checks each sample against an internal golden model.
//  Emits one result beat per vector on a valid/ready stream, then reports pass/fail.
//  Sits beside the combinational netlist as its driver and checker. It feeds the network's
//  inputs and consumes its outputs.
// PARAMETERS
//  SETTLE_CYCLES  2  cycles inputs are held stable before y is sampled (legal range 1..15)
//  ERR_W          5  width of err_count (must hold up to 16)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous assert, active-low reset
//  start        in   1      1-cycle pulse; begins a sweep when idle
//  busy         out  1      high from accepted start until done
//  done         out  1      1-cycle pulse after the last beat is accepted
//  pass         out  1      valid with done and held until next start; 1 = zero mismatches
//  err_count    out  ERR_W  mismatches in the current or last sweep
//  a,b,c,d      out  1      drive to the network; {a,b,c,d} = vector index v[3:0]
//  y_in         in   6      network outputs {y6,y5,y4,y3,y2,y1}
//  res_valid    out  1      result beat valid
//  res_ready    in   1      downstream accepts the beat
//  res_vec      out  4      vector index of this beat
//  res_y        out  6      sampled y_in
//  res_err      out  1      sampled y_in differs from the golden value
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - FSM=IDLE; a..d=0, busy=0, done=0, pass=0, err_count=0, res_*=0.
//   - Reset mid-sweep aborts immediately. No done pulse; the partial beat is lost.
//  Golden model (combinational on v)
//   - y1=a&~b
//   - y2=(a&b)|c|d
//   - y3=~(a&b)^~(c|d)
//   - y4=~((a^c)&~(b^d))
//   - y5=~(y1|y2)
//   - y6=~(y3^y4)
//  FSM states: IDLE -> DRIVE -> SAMPLE -> EMIT -> (DRIVE | FIN) -> IDLE
//   - IDLE
//     - On start: v=0, err_count=0, pass=0, busy=1, go to DRIVE.
//     - start while busy is ignored.
//   - DRIVE
//     - {a,b,c,d}=v is registered, so outputs change on entry.
//     - Settle counter loads SETTLE_CYCLES-1 and decrements to 0, then go to SAMPLE.
//   - SAMPLE
//     - Register res_y=y_in, res_vec=v, res_err=(y_in!=golden(v)).
//     - If res_err, err_count+=1; saturate at all-ones.
//     - Go to EMIT.
//   - EMIT
//     - res_valid=1. res_vec, res_y and res_err are held stable until res_valid&res_ready.
//     - On accept: if v==15 go to FIN, else v+=1 and go to DRIVE.
//     - a..d hold the current v throughout EMIT.
//   - FIN
//     - done=1 for 1 cycle, pass=(err_count==0), busy=0, then IDLE.
//     - a..d return to 0 in IDLE.
//  Latency: each vector takes SETTLE_CYCLES+2 cycles with res_ready tied high.
//   - A sweep with ready tied high, SETTLE_CYCLES=2, takes 16*4=64 cycles, plus 1 for FIN.
//  Boundaries
//   - v does not wrap; the sweep ends after v=15.
//   - A start pulse in the FIN cycle is ignored.
//   - A start pulse in the first IDLE cycle after FIN is accepted.
//   - res_ready low indefinitely stalls the FSM in EMIT; no beat is dropped or duplicated.
//   - y_in is sampled only in SAMPLE. Glitches on y_in in any other state have no effect.
// TESTING
//  T1: Correct network, ready=1, start pulse
//   - 16 beats with res_vec 0..15.
//   - v=0 gives res_y=6'h18; v=8 gives 6'h21; v=15 gives 6'h0A.
//   - done gives pass=1 and err_count=0.
//  T2: y_in forced to 6'h00
//   - Every vector with nonzero golden value flags res_err.
//   - pass=0 and err_count equals the count of nonzero golden vectors.
//  T3: ready toggled randomly, stalled 10 cycles at v=5
//   - res_vec, res_y and res_err stay stable while stalled.
//   - Exactly 16 beats in order.
//  T4: rst_n pulsed low during EMIT of v=7
//   - All outputs return to reset values asynchronously and no done pulse occurs.
//   - A new start restarts from v=0.
//  T5: Second start while busy and in the FIN cycle
//   - Both are ignored; exactly one sweep runs.
//   - A start one cycle after done begins a new sweep and clears err_count.
//  T6: SETTLE_CYCLES=1 and SETTLE_CYCLES=15
//   - The gap from a..d change to the SAMPLE capture equals the parameter.
//   - Results match T1.

Source files
------------

// File: rtl/complex_logic_sweeper.sv
// Exhaustive driver/checker for the 4-input, 6-output complex_logic network:
// walks all 16 input vectors, samples y after a settle window and streams one result beat per vector.
module complex_logic_sweeper #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  input  logic [5:0]       y_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_vec,
  output logic [5:0]       res_y,
  output logic             res_err
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] LAST_VEC    = 4'd15;

  typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, EMIT, FIN} state_t;

  state_t     state, state_nxt;
  logic [3:0] vec;
  logic [3:0] settle;
  logic       accept;
  logic       mismatch;

  function automatic logic [5:0] golden(input logic [3:0] v);
    logic ga, gb, gc, gd;
    logic y1, y2, y3, y4, y5, y6;
    {ga, gb, gc, gd} = v;
    y1 = ga & ~gb;
    y2 = (ga & gb) | gc | gd;
    y3 = ~(ga & gb) ^ ~(gc | gd);
    y4 = ~((ga ^ gc) & ~(gb ^ gd));
    y5 = ~(y1 | y2);
    y6 = ~(y3 ^ y4);
    return {y6, y5, y4, y3, y2, y1};
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  assign accept   = res_valid & res_ready;
  assign mismatch = (y_in != golden(vec));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (settle == 4'd0) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = EMIT;
      EMIT:    if (accept) state_nxt = (vec == LAST_VEC) ? FIN : DRIVE;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Network drive, result beat and sweep status all follow the FSM transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec          <= '0;
      settle       <= '0;
      {a, b, c, d} <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
      res_valid    <= 1'b0;
      res_vec      <= '0;
      res_y        <= '0;
      res_err      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            vec          <= '0;
            {a, b, c, d} <= '0;
            settle       <= SETTLE_LOAD;
            err_count    <= '0;
            pass         <= 1'b0;
            busy         <= 1'b1;
          end
        end
        DRIVE: begin
          if (settle != 4'd0) settle <= settle - 4'd1;
        end
        SAMPLE: begin
          res_y     <= y_in;
          res_vec   <= vec;
          res_err   <= mismatch;
          res_valid <= 1'b1;
          if (mismatch) err_count <= sat_inc(err_count);
        end
        EMIT: begin
          if (accept) begin
            res_valid <= 1'b0;
            if (vec == LAST_VEC) begin
              done <= 1'b1;
              pass <= (err_count == '0);
              busy <= 1'b0;
            end else begin
              vec          <= vec + 4'd1;
              {a, b, c, d} <= vec + 4'd1;
              settle       <= SETTLE_LOAD;
            end
          end
        end
        FIN: begin
          done         <= 1'b0;
          {a, b, c, d} <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
